// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 encryption engine.
// The RC4_DROP_EN macro adds the keystream-discard state to the FSM.
package rc4_pkg;

    localparam int SBOX_SIZE = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
`ifdef RC4_DROP_EN
        ST_DROP,
`endif
        ST_READY,
        ST_GEN,
        ST_OUT
    } state_e;

    typedef enum logic [1:0] {
        WR_NONE,
        WR_INIT,
        WR_SWAP
    } wr_mode_e;

endpackage

// File: rtl/rc4_sbox.sv
// 256x8 RC4 permutation store: two combinational read ports, and either a
// single init write or a two-entry swap write per cycle.
module rc4_sbox (
    input  logic       clk,
    input  logic [7:0] rd_addr_a_i,
    input  logic [7:0] rd_addr_b_i,
    output logic [7:0] rd_data_a_o,
    output logic [7:0] rd_data_b_o,
    input  logic [1:0] wr_mode_i,
    input  logic [7:0] wr_addr_a_i,
    input  logic [7:0] wr_addr_b_i,
    input  logic [7:0] wr_data_a_i,
    input  logic [7:0] wr_data_b_i
);
    import rc4_pkg::*;

    byte_t mem_q [SBOX_SIZE];

    assign rd_data_a_o = mem_q[rd_addr_a_i];
    assign rd_data_b_o = mem_q[rd_addr_b_i];

    // NOTE: no reset on the array; INIT rewrites every entry before any read.
    always_ff @(posedge clk) begin
        if (wr_mode_i == WR_INIT) begin
            mem_q[wr_addr_a_i] <= wr_data_a_i;
        end else if (wr_mode_i == WR_SWAP) begin
            mem_q[wr_addr_a_i] <= wr_data_a_i;
            mem_q[wr_addr_b_i] <= wr_data_b_i;
        end
    end

endmodule

// File: rtl/rc4_encrypt_engine.sv
// Streaming RC4 encryptor: KSA sequencer, one ciphertext byte per handshake.
// Define RC4_DROP_EN to discard DROP_N keystream bytes after the KSA.
module rc4_encrypt_engine #(
    parameter int KEY_BYTES = 16,
    parameter int KLW       = 5,
    parameter int DROP_N    = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [KEY_BYTES*8-1:0] key,
    input  logic [KLW-1:0]         key_len,
    input  logic                   start,
    output logic                   busy,
    output logic                   key_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);
    import rc4_pkg::*;

    localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    state_e                    state_q, state_d;
    byte_t                     i_q, i_d, j_q, j_d;
    byte_t                     pt_q, pt_d, si_q, si_d, out_q, out_d;
    logic [KIW-1:0]            k_q, k_d;
    logic [KEY_BYTES-1:0][7:0] key_q, key_d;
    logic [KLW-1:0]            klen_q, klen_d;

    byte_t    rd_addr_a, rd_addr_b, rd_data_a, rd_data_b;
    byte_t    wr_addr_a, wr_addr_b, wr_data_a, wr_data_b;
    wr_mode_e wr_mode;

    byte_t i_inc, key_byte, j_ksa, j_prga, j_gen, t_gen, ks;
    logic  i_last, k_last;

`ifdef RC4_DROP_EN
    localparam int DCW = (DROP_N > 1) ? $clog2(DROP_N) : 1;
    logic [DCW-1:0] drop_q, drop_d;
`endif

    assign i_inc    = i_q + 8'd1;
    assign i_last   = (i_q == 8'hFF);
    assign key_byte = key_q[k_q];
    assign k_last   = (KLW'(k_q) == klen_q - KLW'(1));
    assign j_ksa    = j_q + rd_data_a + key_byte;
    assign j_prga   = j_q + rd_data_a;
    // GEN uses S[i+1] prefetched in READY, freeing port A to read S[j'].
    assign j_gen    = j_q + si_q;
    assign t_gen    = si_q + rd_data_a;
    assign ks       = (t_gen == i_inc) ? rd_data_a :
                      (t_gen == j_gen) ? si_q : rd_data_b;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        rd_addr_a = i_q;
        case (state_q)
            ST_READY: rd_addr_a = i_inc;
            ST_GEN:   rd_addr_a = j_gen;
`ifdef RC4_DROP_EN
            ST_DROP:  rd_addr_a = i_inc;
`endif
            default:  ;
        endcase
    end

    always_comb begin
        rd_addr_b = j_q;
        case (state_q)
            ST_KSA:  rd_addr_b = j_ksa;
            ST_GEN:  rd_addr_b = t_gen;
`ifdef RC4_DROP_EN
            ST_DROP: rd_addr_b = j_prga;
`endif
            default: ;
        endcase
    end

    rc4_sbox u_sbox (
        .clk         (clk),
        .rd_addr_a_i (rd_addr_a),
        .rd_addr_b_i (rd_addr_b),
        .rd_data_a_o (rd_data_a),
        .rd_data_b_o (rd_data_b),
        .wr_mode_i   (wr_mode),
        .wr_addr_a_i (wr_addr_a),
        .wr_addr_b_i (wr_addr_b),
        .wr_data_a_i (wr_data_a),
        .wr_data_b_i (wr_data_b)
    );

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        key_d     = key_q;
        klen_d    = klen_q;
        pt_d      = pt_q;
        si_d      = si_q;
        out_d     = out_q;
        wr_mode   = WR_NONE;
        wr_addr_a = i_q;
        wr_addr_b = j_q;
        wr_data_a = i_q;
        wr_data_b = 8'h00;
`ifdef RC4_DROP_EN
        drop_d    = drop_q;
`endif
        if (start) begin
            key_d   = key;
            klen_d  = (key_len == '0 || key_len > KLW'(KEY_BYTES)) ? KLW'(KEY_BYTES) : key_len;
            i_d     = 8'h00;
            j_d     = 8'h00;
            k_d     = '0;
            state_d = ST_INIT;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_INIT: begin
                    wr_mode = WR_INIT;
                    i_d     = i_inc;
                    if (i_last) state_d = ST_KSA;
                end
                ST_KSA: begin
                    wr_mode   = WR_SWAP;
                    wr_data_a = rd_data_b;
                    wr_addr_b = j_ksa;
                    wr_data_b = rd_data_a;
                    i_d       = i_inc;
                    j_d       = j_ksa;
                    k_d       = k_last ? '0 : k_q + KIW'(1);
                    if (i_last) begin
                        j_d     = 8'h00;
                        k_d     = '0;
                        state_d = ST_READY;
`ifdef RC4_DROP_EN
                        if (DROP_N > 0) begin
                            drop_d  = '0;
                            state_d = ST_DROP;
                        end
`endif
                    end
                end
`ifdef RC4_DROP_EN
                ST_DROP: begin
                    wr_mode   = WR_SWAP;
                    wr_addr_a = i_inc;
                    wr_data_a = rd_data_b;
                    wr_addr_b = j_prga;
                    wr_data_b = rd_data_a;
                    i_d       = i_inc;
                    j_d       = j_prga;
                    drop_d    = drop_q + DCW'(1);
                    if (drop_q == DCW'(DROP_N - 1)) state_d = ST_READY;
                end
`endif
                ST_READY: begin
                    si_d = rd_data_a;
                    if (in_valid) begin
                        pt_d    = in_data;
                        state_d = ST_GEN;
                    end
                end
                ST_GEN: begin
                    wr_mode   = WR_SWAP;
                    wr_addr_a = i_inc;
                    wr_data_a = rd_data_a;
                    wr_addr_b = j_gen;
                    wr_data_b = si_q;
                    i_d       = i_inc;
                    j_d       = j_gen;
                    out_d     = pt_q ^ ks;
                    state_d   = ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) state_d = ST_READY;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            i_q     <= 8'h00;
            j_q     <= 8'h00;
            k_q     <= '0;
            key_q   <= '0;
            klen_q  <= '0;
            pt_q    <= 8'h00;
            si_q    <= 8'h00;
            out_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            key_q   <= key_d;
            klen_q  <= klen_d;
            pt_q    <= pt_d;
            si_q    <= si_d;
            out_q   <= out_d;
        end
    end

`ifdef RC4_DROP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_q <= '0;
        else        drop_q <= drop_d;
    end
`endif

    assign busy      = (state_q == ST_INIT) || (state_q == ST_KSA)
`ifdef RC4_DROP_EN
                       || (state_q == ST_DROP)
`endif
                       ;
    assign key_ready = (state_q == ST_READY) || (state_q == ST_GEN) || (state_q == ST_OUT);
    assign in_ready  = (state_q == ST_READY);
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_q;

endmodule

// File: tb/tb_rc4_encrypt_engine.sv
// Directed-vector bench for rc4_encrypt_engine (default build, no keystream drop).
module tb_rc4_encrypt_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key;
    logic [4:0]   key_len;
    logic         start;
    logic         busy, key_ready;
    logic [7:0]   in_data;
    logic         in_valid, in_ready;
    logic [7:0]   out_data;
    logic         out_valid, out_ready;

    int passed = 0;
    int total  = 0;

    logic [7:0] ct_key    [9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] ct_wiki   [5]  = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    logic [7:0] ct_secret [14] = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B,
                                   8'h38, 8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
    logic [7:0] model_ks  [8];

    rc4_encrypt_engine #(.KEY_BYTES(16), .KLW(5), .DROP_N(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .key_len   (key_len),
        .start     (start),
        .busy      (busy),
        .key_ready (key_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] pack_key(input string s);
        logic [127:0] r = '0;
        for (int n = 0; n < s.len(); n++) r[8*n +: 8] = s[n];
        return r;
    endfunction

    // Straight RC4 reference: KSA then n PRGA bytes into model_ks.
    task automatic rc4_model(input logic [127:0] k, input int len, input int n);
        logic [7:0] s [256];
        logic [7:0] tmp;
        int ii, jj;
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        jj = 0;
        for (int x = 0; x < 256; x++) begin
            jj = (jj + int'(s[x]) + int'(k[8*(x % len) +: 8])) % 256;
            tmp = s[x]; s[x] = s[jj]; s[jj] = tmp;
        end
        ii = 0; jj = 0;
        for (int x = 0; x < n; x++) begin
            ii = (ii + 1) % 256;
            jj = (jj + int'(s[ii])) % 256;
            tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
            model_ks[x] = s[(int'(s[ii]) + int'(s[jj])) % 256];
        end
    endtask

    task automatic pulse_start(input logic [127:0] k, input logic [4:0] l);
        key = k; key_len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_key_ready(output int cycles);
        cycles = 0;
        while (!key_ready && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    // Handshake one byte in and wait for its ciphertext; leaves the block in OUT.
    task automatic xfer(input logic [7:0] pt, output logic [7:0] ct, output int lat);
        int guard = 0;
        in_data = pt; in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        ct = out_data;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 8'h00; key = '0; key_len = '0;
        #2 reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b want 0", busy);           else passed++;
        total++; if (key_ready !== 1'b0) $display("FAIL reset_key_ready: got %b want 0", key_ready); else passed++;
        total++; if (in_ready !== 1'b0)  $display("FAIL reset_in_ready: got %b want 0", in_ready);   else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data);  else passed++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_key_plaintext();
        string pt = "Plaintext";
        logic [7:0] ct;
        int cyc, lat;
        pulse_start(pack_key("Key"), 5'd3);
        total++; if (busy !== 1'b1) $display("FAIL key_busy_after_start: got %b want 1", busy); else passed++;
        wait_key_ready(cyc);
        total++; if (cyc !== 512) $display("FAIL key_ready_latency: got %0d want 512", cyc); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL key_busy_when_ready: got %b want 0", busy); else passed++;
        for (int b = 0; b < 9; b++) begin
            xfer(pt[b], ct, lat);
            total++; if (ct !== ct_key[b]) $display("FAIL key_ct[%0d]: got %h want %h", b, ct, ct_key[b]); else passed++;
            accept();
        end
    endtask

    task automatic test_wiki_stall();
        string pt = "pedia";
        logic [7:0] ct;
        int cyc, lat;
        pulse_start(pack_key("Wiki"), 5'd4);
        wait_key_ready(cyc);
        total++; if (cyc !== 512) $display("FAIL wiki_ready_latency: got %0d want 512", cyc); else passed++;
        for (int b = 0; b < 5; b++) begin
            xfer(pt[b], ct, lat);
            total++; if (ct !== ct_wiki[b]) $display("FAIL wiki_ct[%0d]: got %h want %h", b, ct, ct_wiki[b]); else passed++;
            if (b == 0) begin
                total++; if (lat !== 1) $display("FAIL wiki_out_latency: got %0d want 1", lat); else passed++;
            end
            if (b == 2) begin
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    total++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", s, out_valid); else passed++;
                    total++; if (out_data !== ct_wiki[2]) $display("FAIL stall_data[%0d]: got %h want %h", s, out_data, ct_wiki[2]); else passed++;
                    total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b want 0", s, in_ready); else passed++;
                end
            end
            accept();
        end
    endtask

    task automatic test_back_to_back();
        string pt = "Attack at dawn";
        int cyc, idx, got, last;
        bit hs;
        pulse_start(pack_key("Secret"), 5'd6);
        wait_key_ready(cyc);
        idx = 0; got = 0; last = 0; cyc = 0;
        in_data = pt[0]; in_valid = 1'b1; out_ready = 1'b1;
        while (got < 14 && cyc < 200) begin
            hs = in_ready && in_valid;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                idx++;
                if (idx < 14) in_data = pt[idx];
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                total++; if (out_data !== ct_secret[got]) $display("FAIL b2b_ct[%0d]: got %h want %h", got, out_data, ct_secret[got]); else passed++;
                if (got > 0) begin
                    total++; if (cyc - last !== 3) $display("FAIL b2b_interval[%0d]: got %0d want 3", got, cyc - last); else passed++;
                end
                last = cyc;
                got++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (got !== 14) $display("FAIL b2b_count: got %0d want 14", got); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_key_len();
        logic [127:0] k16 = 128'h100F0E0D0C0B0A090807060504030201;
        logic [4:0]   lens [3] = '{5'd16, 5'd0, 5'd20};
        logic [7:0]   ct;
        int cyc, lat;
        rc4_model(k16, 16, 8);
        for (int t = 0; t < 3; t++) begin
            pulse_start(k16, lens[t]);
            wait_key_ready(cyc);
            for (int b = 0; b < 8; b++) begin
                xfer(8'h00, ct, lat);
                total++; if (ct !== model_ks[b]) $display("FAIL keylen%0d_ks[%0d]: got %h want %h", lens[t], b, ct, model_ks[b]); else passed++;
                accept();
            end
        end
    endtask

    task automatic test_rekey();
        string pt_p = "Plaintext";
        string pt_w = "pedia";
        logic [7:0] ct;
        int cyc, lat;
        pulse_start(pack_key("Key"), 5'd3);
        wait_key_ready(cyc);
        for (int b = 0; b < 3; b++) begin
            xfer(pt_p[b], ct, lat);
            total++; if (ct !== ct_key[b]) $display("FAIL rekey_pre_ct[%0d]: got %h want %h", b, ct, ct_key[b]); else passed++;
            accept();
        end
        xfer(pt_p[3], ct, lat);
        total++; if (out_valid !== 1'b1) $display("FAIL rekey_pending: got %b want 1", out_valid); else passed++;
        pulse_start(pack_key("Wiki"), 5'd4);
        total++; if (out_valid !== 1'b0) $display("FAIL rekey_drop_valid: got %b want 0", out_valid); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL rekey_busy: got %b want 1", busy); else passed++;
        wait_key_ready(cyc);
        total++; if (cyc !== 512) $display("FAIL rekey_ready_latency: got %0d want 512", cyc); else passed++;
        for (int b = 0; b < 5; b++) begin
            xfer(pt_w[b], ct, lat);
            total++; if (ct !== ct_wiki[b]) $display("FAIL rekey_ct[%0d]: got %h want %h", b, ct, ct_wiki[b]); else passed++;
            accept();
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] ct;
        int cyc, lat;
        pulse_start(pack_key("Wiki"), 5'd4);
        repeat (300) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) $display("FAIL ksa_busy_before_reset: got %b want 1", busy); else passed++;
        #2 reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0)      $display("FAIL ksa_reset_busy: got %b want 0", busy);           else passed++;
        total++; if (key_ready !== 1'b0) $display("FAIL ksa_reset_key_ready: got %b want 0", key_ready); else passed++;
        total++; if (in_ready !== 1'b0)  $display("FAIL ksa_reset_in_ready: got %b want 0", in_ready);   else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL ksa_reset_out_valid: got %b want 0", out_valid); else passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) $display("FAIL idle_after_reset_busy: got %b want 0", busy); else passed++;
        pulse_start(pack_key("Wiki"), 5'd4);
        wait_key_ready(cyc);
        xfer(8'h70, ct, lat);
        total++; if (ct !== ct_wiki[0]) $display("FAIL out_before_reset_ct: got %h want %h", ct, ct_wiki[0]); else passed++;
        #2 reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL out_reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL out_reset_out_data: got %h want 00", out_data);  else passed++;
        total++; if (key_ready !== 1'b0) $display("FAIL out_reset_key_ready: got %b want 0", key_ready); else passed++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_key_plaintext();
        test_wiki_stall();
        test_back_to_back();
        test_key_len();
        test_rekey();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
